// File: rtl/spi_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter_pkg
// Purpose  : State encodings, owner ids and grant-selection helper for the
//            shared SPI pin arbiter.
// Revision : 1.0
// ============================================================================
package spi_bus_arbiter_pkg;

  localparam int STATE_W = 2;
  localparam int GUARD_W = 8;
  localparam int HOLD_W  = 16;

  localparam logic [STATE_W-1:0] ARB_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ARB_OWN_F = 2'd1;
  localparam logic [STATE_W-1:0] ARB_OWN_E = 2'd2;
  localparam logic [STATE_W-1:0] ARB_GUARD = 2'd3;

  localparam logic OWNER_F = 1'b0;
  localparam logic OWNER_E = 1'b1;

  // On a tie the requester that was not served last wins.
  function automatic logic [STATE_W-1:0] arb_pick(input logic elig_f,
                                                  input logic elig_e,
                                                  input logic last);
    if (elig_f && elig_e) begin
      return (last == OWNER_E) ? ARB_OWN_F : ARB_OWN_E;
    end else if (elig_f) begin
      return ARB_OWN_F;
    end else if (elig_e) begin
      return ARB_OWN_E;
    end else begin
      return ARB_IDLE;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter_if
// Purpose  : Requester handshakes and shared SPI pin group of the arbiter.
// Revision : 1.0
// ============================================================================
interface spi_bus_arbiter_if;

  logic spi_lock;
  logic flash_req;
  logic eeprom_req;
  logic flash_gnt;
  logic eeprom_gnt;
  logic flash_cs_n;
  logic flash_d;
  logic flash_c;
  logic eeprom_cs_n;
  logic eeprom_d;
  logic eeprom_c;
  logic flash_q;
  logic eeprom_q;
  logic flash_s;
  logic eeprom_s;
  logic spi_d;
  logic spi_c;
  logic spi_q;
  logic busy;
  logic hold_timeout;

  modport slave (
    input  spi_lock, flash_req, eeprom_req,
    input  flash_cs_n, flash_d, flash_c,
    input  eeprom_cs_n, eeprom_d, eeprom_c,
    input  spi_q,
    output flash_gnt, eeprom_gnt, flash_q, eeprom_q,
    output flash_s, eeprom_s, spi_d, spi_c,
    output busy, hold_timeout
  );

  modport master (
    output spi_lock, flash_req, eeprom_req,
    output flash_cs_n, flash_d, flash_c,
    output eeprom_cs_n, eeprom_d, eeprom_c,
    output spi_q,
    input  flash_gnt, eeprom_gnt, flash_q, eeprom_q,
    input  flash_s, eeprom_s, spi_d, spi_c,
    input  busy, hold_timeout
  );

endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Purpose  : Round-robin owner of the shared SPI pins between the flash and
//            EEPROM requesters, with chip-select guard gap and hold watchdog.
// Revision : 1.0
// ============================================================================
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES = 8,
  parameter int HOLD_MAX     = 65535
) (
  input  logic                 clk_dot4x,
  input  logic                 rst,
  spi_bus_arbiter_if.slave     bus
);

  localparam logic [GUARD_W-1:0] C_GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  C_HOLD_MAX   = HOLD_W'(HOLD_MAX);
  localparam logic               C_WDOG_EN    = (HOLD_MAX != 0);

  logic               r_flash_req;
  logic               r_eeprom_req;
  logic               r_lock;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic [GUARD_W-1:0] r_guard_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_flash_stale;
  logic               r_eeprom_stale;
  logic               r_last;
  logic               r_hold_timeout;
  logic               r_flash_s;
  logic               r_eeprom_s;
  logic               r_spi_d;
  logic               r_spi_c;

  logic               w_elig_f;
  logic               w_elig_e;
  logic               w_own;
  logic               w_hold_expired;
  logic               w_timeout;
  logic               w_keep_f;
  logic               w_keep_e;
  logic               w_flash_gnt;
  logic               w_eeprom_gnt;
  logic               w_busy;
  logic               w_flash_q;
  logic               w_eeprom_q;
  logic               w_flash_s_nxt;
  logic               w_eeprom_s_nxt;
  logic               w_spi_d_nxt;
  logic               w_spi_c_nxt;

  // Sampling stage for the request/lock levels; all decisions use these.
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_flash_req  <= 1'b0;
      r_eeprom_req <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_flash_req  <= bus.flash_req;
      r_eeprom_req <= bus.eeprom_req;
      r_lock       <= bus.spi_lock;
    end
  end

  assign w_elig_f       = r_flash_req & ~r_lock & ~r_flash_stale;
  assign w_elig_e       = r_eeprom_req & ~r_eeprom_stale;
  assign w_own          = (r_state == ARB_OWN_F) || (r_state == ARB_OWN_E);
  assign w_hold_expired = C_WDOG_EN && (r_hold_cnt == C_HOLD_MAX);

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_state_next = arb_pick(w_elig_f, w_elig_e, r_last);
      end
      ARB_OWN_F: begin
        if (!r_flash_req) begin
          w_state_next = ARB_GUARD;
        end else if (w_hold_expired) begin
          w_state_next = ARB_GUARD;
          w_timeout    = 1'b1;
        end
      end
      ARB_OWN_E: begin
        if (!r_eeprom_req) begin
          w_state_next = ARB_GUARD;
        end else if (w_hold_expired) begin
          w_state_next = ARB_GUARD;
          w_timeout    = 1'b1;
        end
      end
      ARB_GUARD: begin
        if (r_guard_cnt == C_GUARD_LAST) begin
          w_state_next = ARB_IDLE;
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  // Pins follow an owner only while it keeps ownership, so the whole guard
  // gap and the cycle of entry show idle pins.
  always_comb begin
    w_flash_gnt    = (r_state == ARB_OWN_F);
    w_eeprom_gnt   = (r_state == ARB_OWN_E);
    w_busy         = (r_state != ARB_IDLE);
    w_flash_q      = w_flash_gnt & bus.spi_q;
    w_eeprom_q     = w_eeprom_gnt & bus.spi_q;
    w_keep_f       = w_flash_gnt && (w_state_next == ARB_OWN_F);
    w_keep_e       = w_eeprom_gnt && (w_state_next == ARB_OWN_E);
    w_flash_s_nxt  = w_keep_f ? bus.flash_cs_n : 1'b1;
    w_eeprom_s_nxt = w_keep_e ? bus.eeprom_cs_n : 1'b1;
    w_spi_d_nxt    = w_keep_f ? bus.flash_d : (w_keep_e ? bus.eeprom_d : 1'b0);
    w_spi_c_nxt    = w_keep_f ? bus.flash_c : (w_keep_e ? bus.eeprom_c : 1'b0);
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_guard_cnt    <= '0;
      r_hold_cnt     <= '0;
      r_flash_stale  <= 1'b0;
      r_eeprom_stale <= 1'b0;
      r_last         <= OWNER_E;
      r_hold_timeout <= 1'b0;
    end else begin
      r_hold_timeout <= w_timeout;

      if (r_state == ARB_GUARD) begin
        r_guard_cnt <= r_guard_cnt + 8'd1;
      end else begin
        r_guard_cnt <= '0;
      end

      // Preloaded to 1 so the count equals the number of granted cycles.
      if (r_state == ARB_IDLE) begin
        r_hold_cnt <= 16'd1;
      end else if (w_own && (r_hold_cnt != '1)) begin
        r_hold_cnt <= r_hold_cnt + 16'd1;
      end

      if (!r_flash_req) begin
        r_flash_stale <= 1'b0;
      end else if (w_timeout && (r_state == ARB_OWN_F)) begin
        r_flash_stale <= 1'b1;
      end

      if (!r_eeprom_req) begin
        r_eeprom_stale <= 1'b0;
      end else if (w_timeout && (r_state == ARB_OWN_E)) begin
        r_eeprom_stale <= 1'b1;
      end

      if ((r_state == ARB_OWN_F) && (w_state_next == ARB_GUARD)) begin
        r_last <= OWNER_F;
      end else if ((r_state == ARB_OWN_E) && (w_state_next == ARB_GUARD)) begin
        r_last <= OWNER_E;
      end
    end
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_flash_s  <= 1'b1;
      r_eeprom_s <= 1'b1;
      r_spi_d    <= 1'b0;
      r_spi_c    <= 1'b0;
    end else begin
      r_flash_s  <= w_flash_s_nxt;
      r_eeprom_s <= w_eeprom_s_nxt;
      r_spi_d    <= w_spi_d_nxt;
      r_spi_c    <= w_spi_c_nxt;
    end
  end

  assign bus.flash_gnt    = w_flash_gnt;
  assign bus.eeprom_gnt   = w_eeprom_gnt;
  assign bus.busy         = w_busy;
  assign bus.flash_q      = w_flash_q;
  assign bus.eeprom_q     = w_eeprom_q;
  assign bus.flash_s      = r_flash_s;
  assign bus.eeprom_s     = r_eeprom_s;
  assign bus.spi_d        = r_spi_d;
  assign bus.spi_c        = r_spi_c;
  assign bus.hold_timeout = r_hold_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Purpose  : Directed scoreboard bench for spi_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_spi_bus_arbiter;

  localparam int GUARD = 8;
  localparam int HOLD  = 16;

  localparam int EV_GNT_F = 0;
  localparam int EV_REL_F = 1;
  localparam int EV_GNT_E = 2;
  localparam int EV_REL_E = 3;
  localparam int EV_TMO   = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  sb[$];

  spi_bus_arbiter_if bus();

  spi_bus_arbiter #(
    .GUARD_CYCLES (GUARD),
    .HOLD_MAX     (HOLD)
  ) dut (
    .clk_dot4x (clk),
    .rst       (rst),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".flash_gnt"},    {31'd0, bus.flash_gnt},    32'd0);
    chk({tag, ".eeprom_gnt"},   {31'd0, bus.eeprom_gnt},   32'd0);
    chk({tag, ".flash_s"},      {31'd0, bus.flash_s},      32'd1);
    chk({tag, ".eeprom_s"},     {31'd0, bus.eeprom_s},     32'd1);
    chk({tag, ".spi_d"},        {31'd0, bus.spi_d},        32'd0);
    chk({tag, ".spi_c"},        {31'd0, bus.spi_c},        32'd0);
    chk({tag, ".busy"},         {31'd0, bus.busy},         32'd0);
    chk({tag, ".hold_timeout"}, {31'd0, bus.hold_timeout}, 32'd0);
    chk({tag, ".flash_q"},      {31'd0, bus.flash_q},      32'd0);
    chk({tag, ".eeprom_q"},     {31'd0, bus.eeprom_q},     32'd0);
  endtask

  // Monitor: every grant edge and timeout pulse must match the queue head.
  task automatic sb_pop(input int kind);
    ev_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      if ((e.kind != kind) || (e.cyc != cyc)) begin
        n_fail++;
        $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  initial begin
    logic pf;
    logic pe;
    pf = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pf = 1'b0;
        pe = 1'b0;
      end else begin
        if (bus.flash_gnt !== pf)  sb_pop(bus.flash_gnt ? EV_GNT_F : EV_REL_F);
        if (bus.eeprom_gnt !== pe) sb_pop(bus.eeprom_gnt ? EV_GNT_E : EV_REL_E);
        if (bus.hold_timeout === 1'b1) sb_pop(EV_TMO);
        pf = bus.flash_gnt;
        pe = bus.eeprom_gnt;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int r;
    int g;
    rst             = 1'b1;
    bus.spi_lock    = 1'b0;
    bus.flash_req   = 1'b0;
    bus.eeprom_req  = 1'b0;
    bus.flash_cs_n  = 1'b1;
    bus.flash_d     = 1'b0;
    bus.flash_c     = 1'b0;
    bus.eeprom_cs_n = 1'b1;
    bus.eeprom_d    = 1'b0;
    bus.eeprom_c    = 1'b0;
    bus.spi_q       = 1'b1;

    tick(3);
    check_reset("por");
    rst = 1'b0;
    tick(2);

    // Flash alone: grant two edges after the request, pins one cycle later.
    bus.flash_req = 1'b1;
    expect_ev(EV_GNT_F, cyc + 2);
    tick(1);
    chk("t1.busy_pre", {31'd0, bus.busy}, 32'd0);
    tick(1);
    chk("t1.busy", {31'd0, bus.busy}, 32'd1);
    chk("t1.flash_gnt", {31'd0, bus.flash_gnt}, 32'd1);
    bus.flash_cs_n  = 1'b0;
    bus.flash_d     = 1'b1;
    bus.flash_c     = 1'b1;
    bus.eeprom_cs_n = 1'b0;
    #1;
    chk("t1.flash_s_lag", {31'd0, bus.flash_s}, 32'd1);
    tick(1);
    chk("t1.flash_s", {31'd0, bus.flash_s}, 32'd0);
    chk("t1.spi_d", {31'd0, bus.spi_d}, 32'd1);
    chk("t1.spi_c", {31'd0, bus.spi_c}, 32'd1);
    chk("t1.eeprom_s", {31'd0, bus.eeprom_s}, 32'd1);
    chk("t1.flash_q", {31'd0, bus.flash_q}, 32'd1);
    chk("t1.eeprom_q", {31'd0, bus.eeprom_q}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.flash_c = ~bus.flash_c;
      tick(1);
    end
    chk("t1.spi_c_live", {31'd0, bus.spi_c}, 32'd1);

    // Asynchronous reset mid-transfer.
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    bus.flash_req   = 1'b0;
    bus.flash_cs_n  = 1'b1;
    bus.flash_d     = 1'b0;
    bus.flash_c     = 1'b0;
    bus.eeprom_cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Tie from cold: flash first, then eeprom after the guard gap.
    bus.flash_req   = 1'b1;
    bus.eeprom_req  = 1'b1;
    bus.eeprom_cs_n = 1'b0;
    expect_ev(EV_GNT_F, cyc + 2);
    tick(4);
    chk("t2.eeprom_s_forced", {31'd0, bus.eeprom_s}, 32'd1);
    chk("t2.eeprom_gnt", {31'd0, bus.eeprom_gnt}, 32'd0);
    chk("t2.eeprom_q", {31'd0, bus.eeprom_q}, 32'd0);
    chk("t2.flash_q", {31'd0, bus.flash_q}, 32'd1);
    bus.flash_req = 1'b0;
    r = cyc;
    expect_ev(EV_REL_F, r + 2);
    expect_ev(EV_GNT_E, r + 2 + GUARD + 1);
    for (int k = 1; k <= GUARD + 2; k++) begin
      tick(1);
      if ((k >= 2) && (k <= GUARD + 1)) begin
        chk("guard.cs", {30'd0, bus.flash_s, bus.eeprom_s}, 32'd3);
        chk("guard.spi_c", {31'd0, bus.spi_c}, 32'd0);
        chk("guard.busy", {31'd0, bus.busy}, 32'd1);
        chk("guard.q", {30'd0, bus.flash_q, bus.eeprom_q}, 32'd0);
      end else if (k == GUARD + 2) begin
        chk("guard.end_idle", {31'd0, bus.busy}, 32'd0);
      end
    end
    bus.flash_cs_n = 1'b0;
    tick(1);
    chk("t2.eeprom_s_lag", {31'd0, bus.eeprom_s}, 32'd1);
    tick(1);
    chk("t2.eeprom_s", {31'd0, bus.eeprom_s}, 32'd0);
    chk("t2.flash_s_forced", {31'd0, bus.flash_s}, 32'd1);
    chk("t2.q_owner_e", {30'd0, bus.flash_q, bus.eeprom_q}, 32'd1);
    bus.eeprom_cs_n = 1'b1;
    bus.flash_cs_n  = 1'b1;
    tick(1);
    bus.eeprom_req = 1'b0;
    expect_ev(EV_REL_E, cyc + 2);
    tick(GUARD + 4);

    // Lock refuses flash; watchdog after HOLD granted cycles.
    bus.spi_lock  = 1'b1;
    bus.flash_req = 1'b1;
    tick(5);
    chk("t3.lock_busy", {31'd0, bus.busy}, 32'd0);
    chk("t3.lock_gnt", {31'd0, bus.flash_gnt}, 32'd0);
    bus.spi_lock = 1'b0;
    g = cyc + 2;
    expect_ev(EV_GNT_F, g);
    expect_ev(EV_REL_F, g + HOLD);
    expect_ev(EV_TMO, g + HOLD);
    tick(4);
    bus.spi_lock = 1'b1;
    tick(3);
    bus.spi_lock = 1'b0;
    tick(HOLD + GUARD + 6);
    chk("t4.stale_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4.stale_gnt", {31'd0, bus.flash_gnt}, 32'd0);

    bus.flash_req = 1'b0;
    tick(2);
    bus.flash_req = 1'b1;
    expect_ev(EV_GNT_F, cyc + 2);
    tick(4);
    bus.flash_req = 1'b0;
    expect_ev(EV_REL_F, cyc + 2);
    tick(GUARD + 6);

    chk("sb.drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
